// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Parametrised Mealy serial-pattern detector.
// It takes one qualified bit per clock and raises `pattern` in the same cycle
// that the last bit of PATTERN arrives. A saturating counter records how many
// matches have occurred since reset or since the last counter clear.
//
// Parameters
//   LEN      pattern length in bits (2..16)
//   PATTERN  the pattern itself; PATTERN[LEN-1] is the first bit received
//   CNT_W    width of the match counter (1..32)
//
// Ports
//   clk         in   rising-edge clock for all state
//   rst         in   synchronous reset, active-high
//   din         in   serial data bit
//   din_vld     in   din qualifier; a bit is consumed only when this is 1
//   overlap_en  in   1 = overlapping detection, 0 = non-overlapping
//   clr_cnt     in   synchronous clear of match_cnt / cnt_sat
//   pattern     out  Mealy match flag (combinational from state and din)
//   match_cnt   out  saturating count of matches
//   cnt_sat     out  sticky flag: match_cnt has reached all-ones
// ---------------------------------------------------------------------------
module seq_detect_param #(
  parameter int             LEN     = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b11000,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             pattern,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // State k counts the pattern bits matched so far (0..LEN-1).
  localparam int             SW      = $clog2(LEN);
  localparam logic [SW-1:0]  LAST    = SW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bit number i of the received stream order (i = 0 is the first bit).
  function automatic logic pat_bit(input int i);
    return PATTERN[LEN-1-i];
  endfunction

  // Length of the longest proper prefix of PATTERN that is a suffix of the
  // sequence "first k pattern bits, then b". When b is the expected bit and
  // k < LEN-1 this is simply k+1. With k = LEN-1 and b completing the
  // pattern it is the overlap restart point of the full pattern.
  function automatic int longest(input int k, input logic b);
    int   res;
    int   idx;
    logic ok;
    logic sb;
    res = 0;
    for (int l = 1; l <= LEN - 1; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          idx = k + 1 - l + j;
          sb  = (idx == k) ? b : pat_bit(idx);
          if (pat_bit(j) != sb) ok = 1'b0;
        end
        if (ok) res = l;
      end
    end
    return res;
  endfunction

  // Flattened next-state table for one value of the incoming bit:
  // entry k occupies bits [k*SW +: SW].
  function automatic logic [LEN*SW-1:0] build_tbl(input logic b);
    logic [LEN*SW-1:0] t;
    t = '0;
    for (int k = 0; k < LEN; k++) begin
      t[k*SW +: SW] = SW'(longest(k, b));
    end
    return t;
  endfunction

  // Both tables are fixed at elaboration; there is no runtime pattern load.
  localparam logic [LEN*SW-1:0] NXT0 = build_tbl(1'b0);
  localparam logic [LEN*SW-1:0] NXT1 = build_tbl(1'b1);

  logic [SW-1:0] state;
  logic [SW-1:0] nxt;
  logic          hit;

  // Match detection and table lookup. The lookup for state LAST with the
  // completing bit already yields the overlap restart point, so the only
  // mode-dependent decision left for the register stage is "restart at 0".
  always_comb begin
    hit = !rst && din_vld && (state == LAST) && (din == PATTERN[0]);
    nxt = din ? NXT1[int'(state)*SW +: SW] : NXT0[int'(state)*SW +: SW];
  end

  assign pattern = hit;

  // State and counter registers. Reset wins over everything; the state only
  // moves on qualified bits so an undriven din between bits has no effect.
  // A clear coinciding with a match behaves as clear-then-count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      if (din_vld) begin
        if (hit && !overlap_en) state <= '0;
        else                    state <= nxt;
      end
      if (clr_cnt) begin
        match_cnt <= hit ? CNT_W'(1) : '0;
        cnt_sat   <= 1'b0;
      end else if (hit && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + 1'b1;
        if (match_cnt == CNT_MAX - 1'b1) cnt_sat <= 1'b1;
      end
    end
  end

endmodule
